// File: rtl/bola.sv
// Ball engine for the two-player paddle game: serve, wall bounces, paddle hits and scoring.
// The ball advances one pixel per step; steps are paced by a speed accumulator.
module bola #(
    parameter int unsigned LIMIAR      = 2500000,
    parameter int unsigned VEL_BASE    = 10,
    parameter int unsigned VEL_MAX     = 60,
    parameter int unsigned TAM_BOLA    = 10,
    parameter int unsigned BARRA_LARG  = 20,
    parameter int unsigned BARRA_ALT   = 60,
    parameter int unsigned LIM_CIMA    = 0,
    parameter int unsigned LIM_BAIXO   = 480,
    parameter int unsigned LIM_ESQ     = 0,
    parameter int unsigned LIM_DIR     = 640,
    parameter int unsigned X_CENTRO    = 315,
    parameter int unsigned Y_CENTRO    = 235,
    parameter int unsigned TEMPO_PONTO = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       saque,
    input  logic [9:0] x_esq,
    input  logic [9:0] y_esq,
    input  logic [9:0] vel_esq,
    input  logic [9:0] x_dir,
    input  logic [9:0] y_dir,
    input  logic [9:0] vel_dir,
    output logic [9:0] x_bola,
    output logic [9:0] y_bola,
    output logic       ponto_esq,
    output logic       ponto_dir,
    output logic       em_jogo
);

    // state   | meaning
    // ESPERA  | ball parked at centre, waiting for the serve button
    // JOGANDO | ball in play, stepping whenever the accumulator reaches LIMIAR
    // PONTO   | point scored, ball frozen until the timer expires
    typedef enum logic [1:0] {ESPERA, JOGANDO, PONTO} estado_t;

    localparam logic [11:0] TAM   = 12'(TAM_BOLA);
    localparam logic [11:0] LARG  = 12'(BARRA_LARG);
    localparam logic [11:0] ALT   = 12'(BARRA_ALT);
    localparam logic [11:0] CIMA  = 12'(LIM_CIMA);
    localparam logic [11:0] BAIXO = 12'(LIM_BAIXO);
    localparam logic [11:0] ESQ   = 12'(LIM_ESQ);
    localparam logic [11:0] DIR   = 12'(LIM_DIR);

    estado_t     estado;
    logic        dx_dir;
    logic        dy_baixo;
    logic [10:0] vel;
    logic [31:0] acc;
    logic [31:0] timer;

    logic [11:0] xb, yb, xe, ye, xd, yd;
    logic        sobre_esq, sobre_dir, bate_esq, bate_dir, sai_esq, sai_dir;

    // Ball speed after a hit: base plus strike speed, clamped at VEL_MAX.
    function automatic logic [10:0] satura(input logic [9:0] v);
        logic [10:0] soma;
        soma = 11'(VEL_BASE) + {1'b0, v};
        return (soma > 11'(VEL_MAX)) ? 11'(VEL_MAX) : soma;
    endfunction

    assign xb = {2'b00, x_bola};
    assign yb = {2'b00, y_bola};
    assign xe = {2'b00, x_esq};
    assign ye = {2'b00, y_esq};
    assign xd = {2'b00, x_dir};
    assign yd = {2'b00, y_dir};

    always_comb begin
        sobre_esq = ((yb + TAM) > ye) && (yb < (ye + ALT));
        sobre_dir = ((yb + TAM) > yd) && (yb < (yd + ALT));
        bate_esq  = !dx_dir && (xb <= (xe + LARG)) && ((xb + TAM) > xe) && sobre_esq;
        bate_dir  = dx_dir && ((xb + TAM) >= xd) && (xb < (xd + LARG)) && sobre_dir;
        sai_esq   = !dx_dir && !bate_esq && (xb <= ESQ);
        sai_dir   = dx_dir && !bate_dir && ((xb + TAM) >= DIR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= ESPERA;
            x_bola    <= 10'(X_CENTRO);
            y_bola    <= 10'(Y_CENTRO);
            dx_dir    <= 1'b1;
            dy_baixo  <= 1'b1;
            vel       <= 11'(VEL_BASE);
            acc       <= '0;
            timer     <= '0;
            ponto_esq <= 1'b0;
            ponto_dir <= 1'b0;
            em_jogo   <= 1'b0;
        end else begin
            ponto_esq <= 1'b0;
            ponto_dir <= 1'b0;
            case (estado)
                ESPERA: begin
                    acc    <= '0;
                    x_bola <= 10'(X_CENTRO);
                    y_bola <= 10'(Y_CENTRO);
                    if (!saque) begin
                        estado  <= JOGANDO;
                        em_jogo <= 1'b1;
                        vel     <= 11'(VEL_BASE);
                    end
                end
                JOGANDO: begin
                    if (acc >= LIMIAR) begin
                        acc <= '0;
                        if (dy_baixo) begin
                            if ((yb + TAM) >= BAIXO) begin
                                dy_baixo <= 1'b0;
                                y_bola   <= y_bola - 10'd1;
                            end else begin
                                y_bola <= y_bola + 10'd1;
                            end
                        end else begin
                            if (yb <= CIMA) begin
                                dy_baixo <= 1'b1;
                                y_bola   <= y_bola + 10'd1;
                            end else begin
                                y_bola <= y_bola - 10'd1;
                            end
                        end
                        // A hit wins over a miss; the loser's side gets the next serve.
                        if (bate_esq) begin
                            dx_dir <= 1'b1;
                            x_bola <= x_bola + 10'd1;
                            vel    <= satura(vel_esq);
                        end else if (bate_dir) begin
                            dx_dir <= 1'b0;
                            x_bola <= x_bola - 10'd1;
                            vel    <= satura(vel_dir);
                        end else if (sai_esq) begin
                            dx_dir    <= 1'b0;
                            ponto_dir <= 1'b1;
                            estado    <= PONTO;
                            em_jogo   <= 1'b0;
                        end else if (sai_dir) begin
                            dx_dir    <= 1'b1;
                            ponto_esq <= 1'b1;
                            estado    <= PONTO;
                            em_jogo   <= 1'b0;
                        end else if (dx_dir) begin
                            x_bola <= x_bola + 10'd1;
                        end else begin
                            x_bola <= x_bola - 10'd1;
                        end
                    end else begin
                        acc <= acc + 32'(vel);
                    end
                end
                PONTO: begin
                    if (timer == TEMPO_PONTO - 1) begin
                        timer  <= '0;
                        x_bola <= 10'(X_CENTRO);
                        y_bola <= 10'(Y_CENTRO);
                        estado <= ESPERA;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                default: estado <= ESPERA;
            endcase
        end
    end

endmodule

// File: tb/tb_bola.sv
// Randomised rally bench for bola, checked every cycle against a pixel-level game model.
module tb_bola;
    localparam int LIM = 4;
    localparam int VB  = 1;
    localparam int VM  = 6;
    localparam int TP  = 8;

    logic       clk = 1'b0;
    logic       reset, saque;
    logic [9:0] x_esq, y_esq, vel_esq, x_dir, y_dir, vel_dir;
    logic [9:0] x_bola, y_bola;
    logic       ponto_esq, ponto_dir, em_jogo;

    bola #(.LIMIAR(LIM), .VEL_BASE(VB), .VEL_MAX(VM), .TEMPO_PONTO(TP)) dut (
        .clk(clk), .reset(reset), .saque(saque),
        .x_esq(x_esq), .y_esq(y_esq), .vel_esq(vel_esq),
        .x_dir(x_dir), .y_dir(y_dir), .vel_dir(vel_dir),
        .x_bola(x_bola), .y_bola(y_bola),
        .ponto_esq(ponto_esq), .ponto_dir(ponto_dir), .em_jogo(em_jogo)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    typedef enum {M_ESPERA, M_JOGO, M_PONTO} modo_t;
    modo_t m_mode;
    int    m_x, m_y, m_dx, m_dy, m_vel, m_acc, m_left;
    bit    m_pe, m_pd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int boost(input int v);
        return (VB + v > VM) ? VM : VB + v;
    endfunction

    function automatic bit overlap(input int yp);
        return (m_y + 10 > yp) && (m_y < yp + 60);
    endfunction

    task automatic model_clock();
        int  nx, ny;
        bit  hl, hr;
        m_pe = 0;
        m_pd = 0;
        if (reset) begin
            m_mode = M_ESPERA; m_x = 315; m_y = 235; m_dx = 1; m_dy = 1;
            m_vel = VB; m_acc = 0; m_left = 0;
            return;
        end
        case (m_mode)
            M_ESPERA: begin
                m_x = 315; m_y = 235; m_acc = 0;
                if (!saque) begin m_mode = M_JOGO; m_vel = VB; end
            end
            M_JOGO: begin
                if (m_acc < LIM) m_acc += m_vel;
                else begin
                    m_acc = 0;
                    if (m_dy < 0 && m_y <= 0) begin m_dy = 1; ny = m_y + 1; end
                    else if (m_dy > 0 && m_y + 10 >= 480) begin m_dy = -1; ny = m_y - 1; end
                    else ny = m_y + m_dy;
                    hl = m_dx < 0 && m_x <= int'(x_esq) + 20 && m_x + 10 > int'(x_esq) && overlap(int'(y_esq));
                    hr = m_dx > 0 && m_x + 10 >= int'(x_dir) && m_x < int'(x_dir) + 20 && overlap(int'(y_dir));
                    nx = m_x;
                    if (hl) begin m_dx = 1; nx = m_x + 1; m_vel = boost(int'(vel_esq)); end
                    else if (hr) begin m_dx = -1; nx = m_x - 1; m_vel = boost(int'(vel_dir)); end
                    else if (m_dx < 0 && m_x <= 0) begin m_pd = 1; m_mode = M_PONTO; m_left = TP; end
                    else if (m_dx > 0 && m_x + 10 >= 640) begin m_pe = 1; m_mode = M_PONTO; m_left = TP; end
                    else nx = m_x + m_dx;
                    m_x = nx;
                    m_y = ny;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin m_mode = M_ESPERA; m_x = 315; m_y = 235; end
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x"}, x_bola, m_x);
        chk({tag, ".y"}, y_bola, m_y);
        chk({tag, ".ponto_esq"}, ponto_esq, m_pe);
        chk({tag, ".ponto_dir"}, ponto_dir, m_pd);
        chk({tag, ".em_jogo"}, em_jogo, (m_mode == M_JOGO));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    function automatic logic [9:0] track(input int y);
        int p;
        p = y - int'($urandom_range(0, 45));
        if (p < 0) p = 0;
        return 10'(p);
    endfunction

    function automatic logic [9:0] strike();
        if ($urandom_range(0, 7) == 0) return 10'($urandom_range(0, 1023));
        return 10'($urandom_range(0, 6));
    endfunction

    initial begin
        bit seen;
        int exp_dx;
        reset = 1'b1; saque = 1'b1;
        x_esq = 10'd20;  y_esq = 10'd900; vel_esq = '0;
        x_dir = 10'd560; y_dir = 10'd900; vel_dir = '0;
        tick("reset");
        tick("reset");
        chk("rst_x", x_bola, 315);
        chk("rst_y", y_bola, 235);
        chk("rst_em_jogo", em_jogo, 0);
        chk("rst_pontos", {ponto_esq, ponto_dir}, 0);

        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick("espera");
        chk("espera_x", x_bola, 315);
        chk("espera_y", y_bola, 235);
        chk("espera_em_jogo", em_jogo, 0);

        saque = 1'b0;
        tick("saque");
        chk("saque_em_jogo", em_jogo, 1);
        saque = 1'b1;
        for (int i = 0; i < 5; i++) tick("passo1");
        chk("passo1_x", x_bola, 316);
        chk("passo1_y", y_bola, 236);
        for (int i = 0; i < 5; i++) tick("passo2");
        chk("passo2_x", x_bola, 317);
        chk("passo2_y", y_bola, 237);

        // Paddles follow the ball so the rally covers hits, boosts and wall bounces.
        for (int i = 0; i < 4000; i++) begin
            y_esq = track(m_y); y_dir = track(m_y);
            vel_esq = strike(); vel_dir = strike();
            tick("rally");
        end

        y_esq = 10'd900; y_dir = 10'd900;
        seen = 0; exp_dx = 1;
        for (int i = 0; i < 6000 && !seen; i++) begin
            tick("fuga");
            seen = ponto_esq | ponto_dir;
            if (m_pd) exp_dx = -1;
        end
        chk("ponto_visto", seen, 1);

        saque = 1'b0;
        for (int i = 0; i < TP; i++) tick("ponto");
        chk("fim_ponto_x", x_bola, 315);
        chk("fim_ponto_y", y_bola, 235);
        chk("fim_ponto_em_jogo", em_jogo, 0);
        tick("resaque");
        saque = 1'b1;
        for (int i = 0; i < 5; i++) tick("resaque_passo");
        chk("resaque_dx", x_bola, 315 + exp_dx);

        for (int i = 0; i < 30; i++) tick("jogo");
        reset = 1'b1;
        tick("reset_meio");
        chk("reset_meio_x", x_bola, 315);
        chk("reset_meio_y", y_bola, 235);
        chk("reset_meio_em_jogo", em_jogo, 0);
        chk("reset_meio_pontos", {ponto_esq, ponto_dir}, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick("pos_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
